// File: rtl/wide_alu_seq.sv
`timescale 1ns/1ps
// Byte-serial sequencer that runs NBYTES-wide ADD/SUB/LSH/RSH/NAND through an 8-bit ALU.
// Optional macro WIDE_ALU_FLAGS_EN enables the zero/parity result flags.
module wide_alu_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero_o,
  output logic                  pari_o,
  output logic [2:0]            alu_cmd,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_sci,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sco
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_LSH  = 3'b001;
  localparam logic [2:0] OP_RSH  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          cin_q, cin_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;

  logic [KW-1:0] byte_s;
  logic [KW+2:0] idx_s;
  logic [7:0]    a_byte_s, b_byte_s;
  logic          first_s, last_s, valid_s, chain_s, sci_s;

  // RSH walks the bytes from the top down; everything else bottom up.
  assign byte_s   = (op_q == OP_RSH) ? (K_LAST - k_q) : k_q;
  assign idx_s    = {byte_s, 3'b000};
  assign a_byte_s = a_q[idx_s +: 8];
  assign b_byte_s = b_q[idx_s +: 8];
  assign first_s  = (k_q == {KW{1'b0}});
  assign last_s   = (k_q == K_LAST);
  assign sci_s    = first_s ? ((op_q == OP_SUB) ? 1'b1 : cin_q) : carry_q;

  // Sequencer next-state and operand latching.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cin_d   = cin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = {KW{1'b0}};
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cin_d   = cin;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU command decode; all drives stay zero outside RUN and for invalid ops.
  always_comb begin
    alu_cmd = 3'b000;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_sci = 1'b0;
    valid_s = 1'b0;
    chain_s = 1'b0;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_ADD: begin
          alu_a = a_byte_s; alu_b = b_byte_s; alu_sci = sci_s;
          valid_s = 1'b1; chain_s = 1'b1;
        end
        OP_SUB: begin
          alu_a = a_byte_s; alu_b = ~b_byte_s; alu_sci = sci_s;
          valid_s = 1'b1; chain_s = 1'b1;
        end
        OP_LSH: begin
          alu_cmd = 3'b001; alu_a = a_byte_s; alu_sci = sci_s;
          valid_s = 1'b1; chain_s = 1'b1;
        end
        OP_RSH: begin
          alu_cmd = 3'b010; alu_a = a_byte_s; alu_sci = sci_s;
          valid_s = 1'b1; chain_s = 1'b1;
        end
        OP_NAND: begin
          alu_cmd = 3'b011; alu_a = a_byte_s; alu_b = b_byte_s;
          valid_s = 1'b1;
        end
        default: begin
          valid_s = 1'b0;
        end
      endcase
    end else begin
      valid_s = 1'b0;
    end
  end

  // Result byte capture and carry chaining.
  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    carry_d  = carry_q;
    if (state_q == S_RUN) begin
      result_d[idx_s +: 8] = valid_s ? alu_rslt : 8'h00;
      carry_d = alu_sco;
      if (last_s) begin
        cout_d = chain_s ? alu_sco : 1'b0;
      end else begin
        cout_d = cout_q;
      end
    end else begin
      carry_d = carry_q;
    end
  end

  // Sequencer and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= {KW{1'b0}};
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      op_q     <= 3'b000;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= {W{1'b0}};
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;

`ifdef WIDE_ALU_FLAGS_EN
  logic zero_q, pari_q;

  function automatic logic parity_of(input logic [W-1:0] v);
    return ^v;
  endfunction

  // Flags are taken from the result as it completes on the last byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b0;
      pari_q <= 1'b0;
    end else if (state_q == S_RUN && last_s) begin
      zero_q <= (result_d == {W{1'b0}});
      pari_q <= parity_of(result_d);
    end else begin
      zero_q <= zero_q;
      pari_q <= pari_q;
    end
  end

  assign zero_o = zero_q;
  assign pari_o = pari_q;
`else
  assign zero_o = 1'b0;
  assign pari_o = 1'b0;
`endif

endmodule

// File: tb/tb_wide_alu_seq.sv
`timescale 1ns/1ps
// Directed bench for wide_alu_seq (NBYTES=2) with a behavioural 8-bit ALU attached.
module tb_wide_alu_seq;
  logic        clk = 1'b0;
  logic        reset, start, cin;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy, done, cout, zero_o, pari_o;
  logic [15:0] result;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sci, alu_sco;

  int checks = 0;
  int errors = 0;

`ifdef WIDE_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  wide_alu_seq #(.NBYTES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .zero_o(zero_o), .pari_o(pari_o), .alu_cmd(alu_cmd), .alu_a(alu_a),
    .alu_b(alu_b), .alu_sci(alu_sci), .alu_rslt(alu_rslt), .alu_sco(alu_sco)
  );

  always #5 clk = ~clk;

  // Reference 8-bit ALU.
  always_comb begin
    logic [8:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sci};
    case (alu_cmd)
      3'b000:  begin alu_rslt = sum[7:0]; alu_sco = sum[8]; end
      3'b001:  begin alu_rslt = {alu_a[6:0], alu_sci}; alu_sco = alu_a[7]; end
      3'b010:  begin alu_rslt = {alu_sci, alu_a[7:1]}; alu_sco = alu_a[0]; end
      3'b011:  begin alu_rslt = ~(alu_a & alu_b); alu_sco = 1'b0; end
      default: begin alu_rslt = 8'h00; alu_sco = 1'b0; end
    endcase
  end

  // Launch one operation and wait (bounded) for done; returns busy-cycle count or -1.
  task automatic do_op(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, output int lat, output logic [7:0] fa,
                       output logic [2:0] fc, output logic [2:0] cor);
    int nb;
    @(negedge clk);
    op = o; a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    fa = alu_a; fc = alu_cmd; cor = 3'b000; lat = -1; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin lat = nb; break; end
      if (busy) begin nb++; cor = cor | alu_cmd; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'b000; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    #12;
    checks++;
    if ({busy, done, cout, zero_o, pari_o} !== 5'b00000 || result !== 16'h0000) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b cout=%b z=%b p=%b result=%h, want all 0",
                         busy, done, cout, zero_o, pari_o, result);
    end
    checks++;
    if (alu_cmd !== 3'b000 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sci !== 1'b0) begin
      errors++; $display("FAIL reset_alu: got cmd=%b a=%h b=%h sci=%b, want 0", alu_cmd, alu_a, alu_b, alu_sci);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add;
    int lat; logic [7:0] fa; logic [2:0] fc, cor;
    do_op(3'b000, 16'h12FF, 16'h0001, 1'b0, lat, fa, fc, cor);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d busy cycles, want 2", lat); end
    checks++;
    if (result !== 16'h1300 || cout !== 1'b0) begin
      errors++; $display("FAIL add_result: got %h cout=%b, want 1300 cout=0", result, cout);
    end
    checks++;
    if (zero_o !== 1'b0 || pari_o !== FLAGS) begin
      errors++; $display("FAIL add_flags: got z=%b p=%b, want z=0 p=%b", zero_o, pari_o, FLAGS);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_sub;
    int lat; logic [7:0] fa; logic [2:0] fc, cor;
    do_op(3'b100, 16'h0100, 16'h0001, 1'b0, lat, fa, fc, cor);
    checks++;
    if (lat !== 2 || result !== 16'h00FF || cout !== 1'b1) begin
      errors++; $display("FAIL sub_noborrow: got lat=%0d %h cout=%b, want 2 00FF cout=1", lat, result, cout);
    end
    do_op(3'b100, 16'h0000, 16'h0001, 1'b1, lat, fa, fc, cor);
    checks++;
    if (result !== 16'hFFFF || cout !== 1'b0) begin
      errors++; $display("FAIL sub_borrow: got %h cout=%b, want FFFF cout=0", result, cout);
    end
    checks++;
    if (zero_o !== 1'b0 || pari_o !== 1'b0) begin
      errors++; $display("FAIL sub_flags: got z=%b p=%b, want 0 0", zero_o, pari_o);
    end
  endtask

  task automatic test_shift;
    int lat; logic [7:0] fa; logic [2:0] fc, cor;
    do_op(3'b001, 16'h8001, 16'h0000, 1'b1, lat, fa, fc, cor);
    checks++;
    if (result !== 16'h0003 || cout !== 1'b1 || fa !== 8'h01 || fc !== 3'b001) begin
      errors++; $display("FAIL lsh: got %h cout=%b first_a=%h cmd=%b, want 0003 1 01 001", result, cout, fa, fc);
    end
    do_op(3'b010, 16'h8001, 16'h0000, 1'b0, lat, fa, fc, cor);
    checks++;
    if (fa !== 8'h80 || fc !== 3'b010) begin
      errors++; $display("FAIL rsh_order: got first_a=%h cmd=%b, want 80 010", fa, fc);
    end
    checks++;
    if (result !== 16'h4000 || cout !== 1'b1 || pari_o !== FLAGS) begin
      errors++; $display("FAIL rsh_result: got %h cout=%b p=%b, want 4000 1 %b", result, cout, pari_o, FLAGS);
    end
  endtask

  task automatic test_nand;
    int lat; logic [7:0] fa; logic [2:0] fc, cor;
    do_op(3'b011, 16'hFFFF, 16'hFFFF, 1'b1, lat, fa, fc, cor);
    checks++;
    if (result !== 16'h0000 || cout !== 1'b0) begin
      errors++; $display("FAIL nand_result: got %h cout=%b, want 0000 0", result, cout);
    end
    checks++;
    if (zero_o !== FLAGS || pari_o !== 1'b0) begin
      errors++; $display("FAIL nand_flags: got z=%b p=%b, want z=%b p=0", zero_o, pari_o, FLAGS);
    end
  endtask

  task automatic test_start_ignored;
    bit seen = 1'b0;
    @(negedge clk);
    op = 3'b000; a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 op = 3'b011; a = 16'hFFFF; b = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; start = 1'b0; break; end
    end
    checks++;
    if (seen !== 1'b1 || result !== 16'h0406 || cout !== 1'b0) begin
      errors++; $display("FAIL start_ignored: got done_seen=%b %h cout=%b, want 1 0406 0", seen, result, cout);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_ignored_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat; logic [7:0] fa; logic [2:0] fc, cor;
    bit seen = 1'b0;
    @(negedge clk);
    op = 3'b000; a = 16'h5555; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, zero_o, pari_o} !== 5'b00000 || result !== 16'h0000 ||
        alu_a !== 8'h00 || alu_b !== 8'h00 || alu_cmd !== 3'b000 || alu_sci !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: got busy=%b done=%b result=%h alu_a=%h alu_b=%h, want all 0",
                         busy, done, result, alu_a, alu_b);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done: got done_seen=%b, want 0", seen); end
    do_op(3'b000, 16'h0001, 16'h0001, 1'b0, lat, fa, fc, cor);
    checks++;
    if (lat !== 2 || result !== 16'h0002) begin
      errors++; $display("FAIL reset_recover: got lat=%0d %h, want 2 0002", lat, result);
    end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1;
    @(negedge clk);
    op = 3'b000; a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = i;
        else begin d2 = i; break; end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 < 0 || d2 < 0 || (d2 - d1) !== 4) begin
      errors++; $display("FAIL back_to_back_period: got done at %0d and %0d, want spacing 4", d1, d2);
    end
    @(negedge clk);
  endtask

  task automatic test_invalid;
    int lat; logic [7:0] fa; logic [2:0] fc, cor;
    do_op(3'b111, 16'hFFFF, 16'hFFFF, 1'b1, lat, fa, fc, cor);
    checks++;
    if (lat !== 2 || result !== 16'h0000 || cout !== 1'b0) begin
      errors++; $display("FAIL invalid_result: got lat=%0d %h cout=%b, want 2 0000 0", lat, result, cout);
    end
    checks++;
    if (cor !== 3'b000 || fa !== 8'h00) begin
      errors++; $display("FAIL invalid_alu_idle: got cmd_or=%b first_a=%h, want 000 00", cor, fa);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_nand();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_invalid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
